sram_bank_arb: RTL and testbench
================================

Name: sram_bank_arb

Overview:
- Two-bank SRAM access arbiter for the FFT working memory.
- Shares the two single-port banks between three requesters: the external-data loader, the butterfly operand reader and the butterfly write-back path.
- Issues the registered per-bank chip-enable, write-enable, address and data, and returns read data with a valid strobe.
- Sits between the central control/AGU logic and the SRAM macros.

Parameters:
- A_WIDTH, 9, bank address width.
- D_WIDTH, 32, data word width.
- STARVE_MAX, 8, consecutive write-back wins before a loader/reader gets forced priority (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ld_req / ld_bank / ld_addr / ld_data  in  1/1/A_WIDTH/D_WIDTH  loader write request
- ld_gnt  out  1  loader request accepted this cycle
- rd_req / rd_bank / rd_addr  in  1/1/A_WIDTH  operand read request
- rd_gnt  out  1  read accepted
- rd_valid  out  1  read data valid
- rd_data  out  D_WIDTH  read data
- wb_req / wb_bank / wb_addr / wb_data  in  1/1/A_WIDTH/D_WIDTH  write-back request
- wb_gnt  out  1  write-back accepted
- flush_in  in  1  drain request
- flush_done_out  out  1  no reads in flight, arbiter idle
- cen0_out, cen1_out  out  1  bank chip enable, active low
- wen0_out, wen1_out  out  1  bank write enable, active low (0 = write)
- a0_out, a1_out  out  A_WIDTH  bank address
- d0_out, d1_out  out  D_WIDTH  bank write data
- q0_in, q1_in  in  D_WIDTH  bank read data, one cycle after the access

Behaviour:
- Reset values:
  - cen*/wen* = 1; a*/d* = 0.
  - rd_valid = 0, rd_data = 0.
  - flush_done_out = 0.
  - Round-robin pointers = loader; starvation counters = 0; FSM = RUN.
- Handshake:
  - Requesters hold req and payload stable until gnt.
  - A gnt is combinational from the current req and arbiter state, and at most one gnt is issued per bank per cycle.
  - One requester may be granted on each bank in the same cycle; bank 0 and bank 1 are arbitrated independently.
- Per-bank priority:
  - Write-back wins, unless that bank's starvation counter equals STARVE_MAX.
  - Loader vs reader is resolved by the per-bank round-robin pointer. The pointer toggles to the other requester after the pointed-to one is granted.
  - When forced priority applies, the round-robin winner beats write-back, and the counter clears.
- Starvation counter:
  - Increments when write-back wins while a loader or reader request to the same bank is pending.
  - Clears when a loader or reader is granted on that bank.
  - Saturates at STARVE_MAX.
- SRAM issue: a grant at cycle T drives the bank's cen=0, wen, a and d at T+1 as registered outputs. With no grant the bank's cen=1, and wen, a and d hold their previous values.
- Read return:
  - The bank tag is pipelined.
  - rd_valid=1 and rd_data equals the q of the tagged bank at T+2 after rd_gnt.
  - Back-to-back reads give one rd_valid per cycle.
- FSM RUN/DRAIN/IDLE:
  - RUN→DRAIN on flush_in.
  - In DRAIN and IDLE all gnt are forced to 0.
  - DRAIN→IDLE when the read pipeline is empty.
  - IDLE holds flush_done_out=1 and returns to RUN when flush_in deasserts.
  - A grant issued in the same cycle flush_in rises still completes.
- Simultaneous ld and rd to different banks are both granted. A same-bank request from a requester not granted this cycle stays pending.
- Reset mid-operation aborts in-flight reads; no rd_valid is produced for them.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt_out[15:0], counting cycles in which any bank had more than one pending requester.
  - Saturates at 16'hFFFF and clears on reset and on entering IDLE.
- Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package:
  - FSM state encodings (RUN=2'd0, DRAIN=2'd1, IDLE=2'd2).
  - Requester index constants (REQ_LD=0, REQ_RD=1, REQ_WB=2).
- One sub-module, bank_arb_slice, instantiated twice: per-bank priority, round-robin pointer, starvation counter and registered SRAM outputs. The top holds the FSM, grant OR-merge and read-return pipe.

Test Plan:
- Reset, then ld_req bank0 addr 9'h005 data 32'hA5A5_0001 → ld_gnt same cycle. Next cycle cen0_out=0, wen0_out=0, a0_out=5, d0_out=32'hA5A5_0001.
- rd_req bank1 addr 9'h010 with model q1_in=32'h1234 → rd_gnt at T. cen1_out=0 and wen1_out=1 at T+1. rd_valid=1 and rd_data=32'h1234 at T+2.
- ld_req and rd_req both bank0 for 4 cycles → grants alternate ld, rd, ld, rd; cen1_out stays 1.
- wb_req and rd_req held on bank0 → wb_gnt for 8 cycles, then rd_gnt on cycle 9 with the counter cleared.
- Three reads back-to-back, flush_in at the third grant → DRAIN; rd_valid for all three reads; flush_done_out=1 two cycles after the last grant; new requests are not granted.
- rst_n pulsed low one cycle after rd_gnt → rd_valid never asserts; all cen*=1 immediately.

Source files
------------

// File: rtl/sram_bank_arb_pkg.sv
// Shared types and constants for the two-bank SRAM arbiter.
package sram_bank_arb_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StIdle  = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_LD  = 0;
  localparam int unsigned REQ_RD  = 1;
  localparam int unsigned REQ_WB  = 2;
  localparam int unsigned NUM_REQ = 3;

endpackage

// File: rtl/bank_arb_slice.sv
// Per-bank arbiter: write-back priority with starvation override, loader/reader
// round-robin, and the registered SRAM control outputs for one bank.
module bank_arb_slice
  import sram_bank_arb_pkg::*;
#(
  parameter int unsigned A_WIDTH    = 9,
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [A_WIDTH-1:0] ld_addr,
  input  logic [D_WIDTH-1:0] ld_data,
  input  logic [A_WIDTH-1:0] rd_addr,
  input  logic [A_WIDTH-1:0] wb_addr,
  input  logic [D_WIDTH-1:0] wb_data,
  output logic [NUM_REQ-1:0] gnt,
  output logic               cen,
  output logic               wen,
  output logic [A_WIDTH-1:0] a,
  output logic [D_WIDTH-1:0] d
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic               rr_ptr_q, rr_ptr_d;  // 0 = loader next, 1 = reader next
  logic [3:0]         starve_q, starve_d;
  logic               lr_pend, forced, pick_rd;
  logic               cen_q, cen_d, wen_q, wen_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [D_WIDTH-1:0] d_q, d_d;

  always_comb begin
    lr_pend = req[REQ_LD] | req[REQ_RD];
    forced  = lr_pend && (starve_q == StarveMax);
    pick_rd = req[REQ_RD] && (!req[REQ_LD] || rr_ptr_q);
    gnt     = '0;
    if (en) begin
      if (req[REQ_WB] && !forced) begin
        gnt[REQ_WB] = 1'b1;
      end else if (lr_pend) begin
        if (pick_rd) gnt[REQ_RD] = 1'b1;
        else         gnt[REQ_LD] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt[REQ_LD])      rr_ptr_d = 1'b1;
    else if (gnt[REQ_RD]) rr_ptr_d = 1'b0;

    starve_d = starve_q;
    if (gnt[REQ_LD] || gnt[REQ_RD]) begin
      starve_d = '0;
    end else if (gnt[REQ_WB] && lr_pend && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Without a grant the bank is deselected and wen/a/d keep their last values.
  always_comb begin
    cen_d = ~|gnt;
    wen_d = wen_q;
    a_d   = a_q;
    d_d   = d_q;
    if (gnt[REQ_LD]) begin
      wen_d = 1'b0;
      a_d   = ld_addr;
      d_d   = ld_data;
    end else if (gnt[REQ_RD]) begin
      wen_d = 1'b1;
      a_d   = rd_addr;
    end else if (gnt[REQ_WB]) begin
      wen_d = 1'b0;
      a_d   = wb_addr;
      d_d   = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
      starve_q <= '0;
      cen_q    <= 1'b1;
      wen_q    <= 1'b1;
      a_q      <= '0;
      d_q      <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      a_q      <= a_d;
      d_q      <= d_d;
    end
  end

  assign cen = cen_q;
  assign wen = wen_q;
  assign a   = a_q;
  assign d   = d_q;

endmodule

// File: rtl/sram_bank_arb.sv
// Two-bank SRAM arbiter top: RUN/DRAIN/IDLE flush FSM, grant merge, read-return pipe.
// Optional macro ARB_STATS_EN adds a saturating conflict-cycle counter output.
module sram_bank_arb
  import sram_bank_arb_pkg::*;
#(
  parameter int unsigned A_WIDTH    = 9,
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_req,
  input  logic               ld_bank,
  input  logic [A_WIDTH-1:0] ld_addr,
  input  logic [D_WIDTH-1:0] ld_data,
  output logic               ld_gnt,
  input  logic               rd_req,
  input  logic               rd_bank,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic               rd_gnt,
  output logic               rd_valid,
  output logic [D_WIDTH-1:0] rd_data,
  input  logic               wb_req,
  input  logic               wb_bank,
  input  logic [A_WIDTH-1:0] wb_addr,
  input  logic [D_WIDTH-1:0] wb_data,
  output logic               wb_gnt,
  input  logic               flush_in,
  output logic               flush_done_out,
  output logic               cen0_out,
  output logic               cen1_out,
  output logic               wen0_out,
  output logic               wen1_out,
  output logic [A_WIDTH-1:0] a0_out,
  output logic [A_WIDTH-1:0] a1_out,
  output logic [D_WIDTH-1:0] d0_out,
  output logic [D_WIDTH-1:0] d1_out,
  input  logic [D_WIDTH-1:0] q0_in,
  input  logic [D_WIDTH-1:0] q1_in
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        conflict_cnt_out
`endif
);

  arb_state_e         state_q, state_d;
  logic               run;
  logic [NUM_REQ-1:0] req_b [2];
  logic [NUM_REQ-1:0] gnt_b [2];
  logic               cen_b [2];
  logic               wen_b [2];
  logic [A_WIDTH-1:0] a_b   [2];
  logic [D_WIDTH-1:0] d_b   [2];
  logic               p1_valid_q, p1_bank_q, rv_q, rv_bank_q;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      req_b[b]         = '0;
      req_b[b][REQ_LD] = ld_req && (ld_bank == 1'(b));
      req_b[b][REQ_RD] = rd_req && (rd_bank == 1'(b));
      req_b[b][REQ_WB] = wb_req && (wb_bank == 1'(b));
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bank_arb_slice #(
      .A_WIDTH   (A_WIDTH),
      .D_WIDTH   (D_WIDTH),
      .STARVE_MAX(STARVE_MAX)
    ) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (run),
      .req    (req_b[b]),
      .ld_addr(ld_addr),
      .ld_data(ld_data),
      .rd_addr(rd_addr),
      .wb_addr(wb_addr),
      .wb_data(wb_data),
      .gnt    (gnt_b[b]),
      .cen    (cen_b[b]),
      .wen    (wen_b[b]),
      .a      (a_b[b]),
      .d      (d_b[b])
    );
  end

  assign ld_gnt   = gnt_b[0][REQ_LD] | gnt_b[1][REQ_LD];
  assign rd_gnt   = gnt_b[0][REQ_RD] | gnt_b[1][REQ_RD];
  assign wb_gnt   = gnt_b[0][REQ_WB] | gnt_b[1][REQ_WB];
  assign cen0_out = cen_b[0];
  assign cen1_out = cen_b[1];
  assign wen0_out = wen_b[0];
  assign wen1_out = wen_b[1];
  assign a0_out   = a_b[0];
  assign a1_out   = a_b[1];
  assign d0_out   = d_b[0];
  assign d1_out   = d_b[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StRun;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush_in)    state_d = StDrain;
      StDrain: if (!p1_valid_q) state_d = StIdle;
      StIdle:  if (!flush_in)   state_d = StRun;
      default:                  state_d = StRun;
    endcase
  end

  // Once stage 1 is empty the last read's data is on rd_data this cycle, so DRAIN reports done.
  always_comb begin
    run            = (state_q == StRun);
    flush_done_out = (state_q == StIdle) || ((state_q == StDrain) && !p1_valid_q);
  end

  // Read return: grant -> SRAM access (stage 1) -> q valid (stage 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid_q <= 1'b0;
      p1_bank_q  <= 1'b0;
      rv_q       <= 1'b0;
      rv_bank_q  <= 1'b0;
    end else begin
      p1_valid_q <= rd_gnt;
      p1_bank_q  <= rd_bank;
      rv_q       <= p1_valid_q;
      rv_bank_q  <= p1_bank_q;
    end
  end

  assign rd_valid = rv_q;
  assign rd_data  = rv_q ? (rv_bank_q ? q1_in : q0_in) : '0;

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        conflict;

  always_comb begin
    conflict = 1'b0;
    for (int b = 0; b < 2; b++) begin
      conflict = conflict | (req_b[b][REQ_LD] & req_b[b][REQ_RD])
                          | (req_b[b][REQ_WB] & (req_b[b][REQ_LD] | req_b[b][REQ_RD]));
    end
    conflict_cnt_d = conflict_cnt_q;
    if ((state_q != StIdle) && (state_d == StIdle)) begin
      conflict_cnt_d = '0;
    end else if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_q <= '0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt_out = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_bank_arb.sv
// Bench for sram_bank_arb: directed scenarios, then random traffic against a reference model.
module tb_sram_bank_arb;

  localparam int SM = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0, ld_bank = 1'b0, rd_req = 1'b0, rd_bank = 1'b0;
  logic        wb_req = 1'b0, wb_bank = 1'b0, flush_in = 1'b0;
  logic [8:0]  ld_addr = '0, rd_addr = '0, wb_addr = '0;
  logic [31:0] ld_data = '0, wb_data = '0;
  logic        ld_gnt, rd_gnt, wb_gnt, rd_valid, flush_done_out;
  logic [31:0] rd_data;
  logic        cen0_out, cen1_out, wen0_out, wen1_out;
  logic [8:0]  a0_out, a1_out;
  logic [31:0] d0_out, d1_out, q0_in, q1_in;
`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt_out;
`endif

  int checks = 0;
  int errors = 0;

  sram_bank_arb #(.A_WIDTH(9), .D_WIDTH(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_bank(ld_bank), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
    .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_req(wb_req), .wb_bank(wb_bank), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .flush_in(flush_in), .flush_done_out(flush_done_out),
    .cen0_out(cen0_out), .cen1_out(cen1_out), .wen0_out(wen0_out), .wen1_out(wen1_out),
    .a0_out(a0_out), .a1_out(a1_out), .d0_out(d0_out), .d1_out(d1_out),
    .q0_in(q0_in), .q1_in(q1_in)
`ifdef ARB_STATS_EN
    , .conflict_cnt_out(conflict_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  // SRAM macro model: synchronous single-port, read data one cycle after access.
  logic        mem_init = 1'b0;
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      mem_init <= 1'b1;
    end else begin
      if (!cen0_out) begin
        if (!wen0_out) mem0[a0_out] <= d0_out;
        else           q0_in <= mem0[a0_out];
      end
      if (!cen1_out) begin
        if (!wen1_out) mem1[a1_out] <= d1_out;
        else           q1_in <= mem1[a1_out];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_req = 1'b0; rd_req = 1'b0; wb_req = 1'b0; flush_in = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     rq[$];
  rd_exp_t     re;
  logic [31:0] ref_mem [2][16];
  int          m_turn [2];
  int          m_starve [2];
  logic [31:0] vals [3];
  int          cyc, ld_i, rd_i, wb_i;
  bit          e_ld, e_rd, e_wb, lp, rp, wp;

  initial begin
    // Reset values
    tick();
    chk("rst_cen0", 32'(cen0_out), 1);
    chk("rst_cen1", 32'(cen1_out), 1);
    chk("rst_wen0", 32'(wen0_out), 1);
    chk("rst_wen1", 32'(wen1_out), 1);
    chk("rst_a0", 32'(a0_out), 0);
    chk("rst_d1", d1_out, 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_flush_done", 32'(flush_done_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Loader write to bank 0
    ld_req = 1'b1; ld_bank = 1'b0; ld_addr = 9'h005; ld_data = 32'hA5A5_0001;
    @(negedge clk);
    chk("ld_gnt", 32'(ld_gnt), 1);
    tick();
    ld_req = 1'b0;
    chk("ld_cen0", 32'(cen0_out), 0);
    chk("ld_wen0", 32'(wen0_out), 0);
    chk("ld_a0", 32'(a0_out), 32'h5);
    chk("ld_d0", d0_out, 32'hA5A5_0001);
    chk("ld_cen1", 32'(cen1_out), 1);

    // Read from bank 1 after preloading it through the loader
    ld_req = 1'b1; ld_bank = 1'b1; ld_addr = 9'h010; ld_data = 32'h0000_1234;
    tick();
    ld_req = 1'b0;
    rd_req = 1'b1; rd_bank = 1'b1; rd_addr = 9'h010;
    @(negedge clk);
    chk("rd_gnt", 32'(rd_gnt), 1);
    tick();
    rd_req = 1'b0;
    chk("rd_cen1", 32'(cen1_out), 0);
    chk("rd_wen1", 32'(wen1_out), 1);
    chk("rd_a1", 32'(a1_out), 32'h10);
    chk("rd_valid_t1", 32'(rd_valid), 0);
    tick();
    chk("rd_valid_t2", 32'(rd_valid), 1);
    chk("rd_data_t2", rd_data, 32'h0000_1234);
    tick();
    chk("rd_valid_t3", 32'(rd_valid), 0);

    // Loader/reader round-robin on bank 0
    do_reset();
    ld_req = 1'b1; ld_bank = 1'b0; ld_addr = 9'h006; ld_data = 32'h1;
    rd_req = 1'b1; rd_bank = 1'b0; rd_addr = 9'h007;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr_ld_%0d", i), 32'(ld_gnt), 32'((i % 2) == 0));
      chk($sformatf("rr_rd_%0d", i), 32'(rd_gnt), 32'((i % 2) == 1));
      tick();
      chk($sformatf("rr_cen1_%0d", i), 32'(cen1_out), 1);
    end
    idle_inputs();

    // Starvation: write-back wins STARVE_MAX times, then the reader is forced through
    do_reset();
    wb_req = 1'b1; wb_bank = 1'b0; wb_addr = 9'h030; wb_data = 32'hBEEF;
    rd_req = 1'b1; rd_bank = 1'b0; rd_addr = 9'h031;
    for (int i = 0; i < SM + 2; i++) begin
      @(negedge clk);
      chk($sformatf("starve_wb_%0d", i), 32'(wb_gnt), 32'(i != SM));
      chk($sformatf("starve_rd_%0d", i), 32'(rd_gnt), 32'(i == SM));
      tick();
    end
    idle_inputs();

    // Flush: three back-to-back reads, flush on the third grant
    do_reset();
    for (int k = 0; k < 3; k++) begin
      vals[k] = 32'hC0DE_0000 + 32'(k);
      ld_req = 1'b1; ld_bank = 1'b0; ld_addr = 9'h021 + 9'(k); ld_data = vals[k];
      tick();
    end
    ld_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_req   = 1'b1;
      rd_bank  = 1'b0;
      rd_addr  = (k < 3) ? 9'h021 + 9'(k) : 9'h021;
      flush_in = (k >= 2) && (k <= 5);
      if (k >= 3) begin
        ld_req = 1'b1; ld_bank = 1'b1; ld_addr = 9'h040; ld_data = 32'h5555;
      end
      @(negedge clk);
      chk($sformatf("fl_rd_gnt_%0d", k), 32'(rd_gnt), 32'((k < 3) || (k == 7)));
      chk($sformatf("fl_ld_gnt_%0d", k), 32'(ld_gnt), 32'(k == 7));
      chk($sformatf("fl_done_%0d", k), 32'(flush_done_out), 32'((k >= 4) && (k <= 6)));
      chk($sformatf("fl_rv_%0d", k), 32'(rd_valid), 32'((k >= 2) && (k <= 4)));
      if ((k >= 2) && (k <= 4)) chk($sformatf("fl_rdata_%0d", k), rd_data, vals[k-2]);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // Reset one cycle after a read grant aborts the read
    rd_req = 1'b1; rd_bank = 1'b1; rd_addr = 9'h010;
    @(negedge clk);
    chk("abort_rd_gnt", 32'(rd_gnt), 1);
    tick();
    rd_req = 1'b0;
    chk("abort_cen1_pre", 32'(cen1_out), 0);
    rst_n = 1'b0;
    #1;
    chk("abort_cen0", 32'(cen0_out), 1);
    chk("abort_cen1", 32'(cen1_out), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_rv_%0d", i), 32'(rd_valid), 0);
    end

    // Random traffic against the reference model (addresses 0x100..0x10F, unused above)
    do_reset();
    for (int b = 0; b < 2; b++) begin
      m_turn[b] = 0;
      m_starve[b] = 0;
      for (int i = 0; i < 16; i++) ref_mem[b][i] = '0;
    end
    cyc = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ld_req && ($urandom_range(0, 9) < 6)) begin
        ld_i = int'($urandom_range(0, 15));
        ld_req = 1'b1; ld_bank = 1'($urandom_range(0, 1));
        ld_addr = 9'h100 + 9'(ld_i); ld_data = $urandom;
      end
      if (!rd_req && ($urandom_range(0, 9) < 6)) begin
        rd_i = int'($urandom_range(0, 15));
        rd_req = 1'b1; rd_bank = 1'($urandom_range(0, 1));
        rd_addr = 9'h100 + 9'(rd_i);
      end
      if (!wb_req && ($urandom_range(0, 9) < 7)) begin
        wb_i = int'($urandom_range(0, 15));
        wb_req = 1'b1; wb_bank = 1'($urandom_range(0, 1));
        wb_addr = 9'h100 + 9'(wb_i); wb_data = $urandom;
      end
      @(negedge clk);
      e_ld = 1'b0; e_rd = 1'b0; e_wb = 1'b0;
      for (int b = 0; b < 2; b++) begin
        lp = ld_req && (int'(ld_bank) == b);
        rp = rd_req && (int'(rd_bank) == b);
        wp = wb_req && (int'(wb_bank) == b);
        if (wp && !((m_starve[b] == SM) && (lp || rp))) begin
          e_wb = 1'b1;
          if ((lp || rp) && (m_starve[b] < SM)) m_starve[b]++;
        end else if (lp || rp) begin
          if (rp && (!lp || (m_turn[b] == 1))) begin
            e_rd = 1'b1; m_turn[b] = 0;
          end else begin
            e_ld = 1'b1; m_turn[b] = 1;
          end
          m_starve[b] = 0;
        end
      end
      chk("rnd_ld_gnt", 32'(ld_gnt), 32'(e_ld));
      chk("rnd_rd_gnt", 32'(rd_gnt), 32'(e_rd));
      chk("rnd_wb_gnt", 32'(wb_gnt), 32'(e_wb));
      if ((rq.size() > 0) && (rq[0].due == cyc)) begin
        re = rq.pop_front();
        chk("rnd_rd_valid", 32'(rd_valid), 1);
        chk("rnd_rd_data", rd_data, re.data);
      end else begin
        chk("rnd_rd_valid", 32'(rd_valid), 0);
      end
      if (e_rd) begin
        re.due  = cyc + 2;
        re.data = ref_mem[rd_bank][rd_i];
        rq.push_back(re);
      end
      if (e_ld) ref_mem[ld_bank][ld_i] = ld_data;
      if (e_wb) ref_mem[wb_bank][wb_i] = wb_data;
      tick();
      cyc++;
      if (e_ld) ld_req = 1'b0;
      if (e_rd) rd_req = 1'b0;
      if (e_wb) wb_req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
